sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

- Expands one 512-bit SHA-256 message block into the 64-word schedule W[0..63] and streams it to the compression rounds, one word per accepted cycle.
- Sits between the block padder (upstream) and the round engine (downstream).
- Holds a 16-word sliding window and computes each new word with the small-sigma functions, registering the result into the window.

## Interface
Parameters:
- NUM_W, 64: words emitted per block; legal range 17..64.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- blk_valid  in  1  upstream block present.
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- blk_data  in  512  message block; word 0 = blk_data[511:480] (big-endian word order).
- flush  in  1  synchronous abort of current block.
- w_valid  out  1  w_data holds a schedule word.
- w_ready  in  1  downstream accepts when w_valid && w_ready.
- w_data  out  32  schedule word W[t].
- w_last  out  1  high with the word at t = NUM_W-1.
- w_idx  out  6  index t of w_data (present only with MSG_SCHED_IDX_EN).

## Operation
- FSM states:
  - IDLE: blk_ready=1, w_valid=0. On block accept, load window[i]=word i, set cnt=0, go to RUN.
  - RUN: blk_ready=0, w_valid=1, w_data=window[0], w_last=(cnt==NUM_W-1).
- Word accept in RUN:
  - Shift window[i]=window[i+1] for i=0..14.
  - window[15] = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32, carries discarded.
  - Increment cnt.
- Expansion runs for every accepted word, including t≥NUM_W-16. Those results go unused; this is harmless.
- Accepting the word at cnt==NUM_W-1 returns the FSM to IDLE.
- Boundary conditions:
  - blk_valid while in RUN is ignored (blk_ready=0); the upstream holds its block.
  - w_ready low stalls: window, cnt and outputs hold unchanged.
  - flush in any state → IDLE next cycle, window contents don't-care. flush has priority over a same-cycle word or block accept.
  - Reset mid-RUN: the block is discarded and the FSM is in IDLE immediately.
- Reset values:
  - state=IDLE, cnt=0, window=0.
  - w_valid=0, w_last=0, w_data=0, w_idx=0.
  - blk_ready=1.

## Timing
- Block accepted on edge N → w_valid=1 with W[0] after edge N; visible in cycle N+1.
- With w_ready held high, W[0..NUM_W-1] appear on NUM_W consecutive cycles.
- After the last accept, blk_ready=1 in the following cycle. Minimum block-to-block period is NUM_W+1 cycles.
- All outputs are registered or decoded from state; no combinational path from w_ready/blk_valid to any output.
- Critical path: sigma0/sigma1 plus a 4-operand 32-bit add (carry-save then one CPA).

## Configuration
- MSG_SCHED_IDX_EN:
  - Defined: w_idx port exists, equals cnt while w_valid, holds value while stalled, 0 in IDLE.
  - Undefined: port and its logic absent. Behaviour is otherwise identical.

## Structure
- Shared package sha256_pkg:
  - WORD_W=32, BLOCK_W=512, WIN_DEPTH=16.
  - FSM state enum {IDLE, RUN}.
  - word_t typedef.
- Instantiates the existing combinational sigma0 and sigma1 modules once each.
- One natural sub-module: sha256_msg_window. It holds the 16×32 shift register with parallel load and shift-enable.
- The adder and FSM stay in the top.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 → W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB with w_last=1; 64 consecutive valid cycles.
- All-zero block → 64 words all 0x00000000; blk_ready returns 1 the cycle after the last accept.
- Random w_ready toggling (~50%) on the "abc" block → identical word sequence, no drops or duplicates. w_data is stable while w_valid && !w_ready.
- blk_valid held high with a second block during RUN → second block accepted only in the IDLE cycle after w_last; its W0 follows.
- flush asserted at t=20 together with w_ready=1 → word 20 not consumed, w_valid=0 next cycle, blk_ready=1. A new block then restarts at W0.
- rst pulsed asynchronously mid-cycle at t=30 → w_valid, w_last, w_data go to 0 immediately, blk_ready=1. With MSG_SCHED_IDX_EN, w_idx also reads 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 widths, word type, FSM states and 4-operand adder
package sha256_pkg;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 512;
  localparam int WIN_DEPTH = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {IDLE, RUN} state_t;

  // Two 3:2 compressor levels feed a single carry-propagate add; top carries drop out (mod 2^32).
  function automatic word_t add4(word_t a, word_t b, word_t c, word_t d);
    word_t s1, c1, s2, c2;
    s1 = a ^ b ^ c;
    c1 = ((a & b) | (a & c) | (b & c)) << 1;
    s2 = s1 ^ c1 ^ d;
    c2 = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
    return s2 + c2;
  endfunction
endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block-in / word-out handshake bundle; w_idx only with MSG_SCHED_IDX_EN
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic               flush;
  logic               w_valid;
  logic               w_ready;
  word_t              w_data;
  logic               w_last;
`ifdef MSG_SCHED_IDX_EN
  logic [5:0]         w_idx;
`endif

  modport master (
    output blk_valid, blk_data, flush, w_ready,
`ifdef MSG_SCHED_IDX_EN
    input  w_idx,
`endif
    input  blk_ready, w_valid, w_data, w_last
  );

  modport slave (
    input  blk_valid, blk_data, flush, w_ready,
`ifdef MSG_SCHED_IDX_EN
    output w_idx,
`endif
    output blk_ready, w_valid, w_data, w_last
  );
endinterface

// File: rtl/sha256_msg_window.sv
// rtl/sha256_msg_window.sv - 16-word schedule window with parallel block load and shift-in
module sha256_msg_window
  import sha256_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [BLOCK_W-1:0]         load_data,
  input  logic                       shift,
  input  word_t                      new_word,
  output word_t [WIN_DEPTH-1:0]      win
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
    end else if (load) begin
      // word 0 sits in the most significant slice of the block
      for (int i = 0; i < WIN_DEPTH; i++)
        win[i] <= load_data[BLOCK_W-1-WORD_W*i -: WORD_W];
    end else if (shift) begin
      for (int i = 0; i < WIN_DEPTH-1; i++)
        win[i] <= win[i+1];
      win[WIN_DEPTH-1] <= new_word;
    end
  end
endmodule

// File: rtl/sigma0.sv
// rtl/sigma0.sv - SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3
module sigma0
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

// File: rtl/sigma1.sv
// rtl/sigma1.sv - SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10
module sigma1
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - expands a 512-bit block into NUM_W schedule words; MSG_SCHED_IDX_EN adds w_idx
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  sha256_msg_schedule_if.slave  bus
);
  localparam logic [5:0] LAST_IDX = 6'(NUM_W-1);

  state_t                 state;
  logic [5:0]             cnt;
  logic                   blk_ready_q;
  logic                   w_valid_q;
  logic                   w_last_q;
  word_t [WIN_DEPTH-1:0]  win;
  word_t                  s0, s1, next_word;
  logic                   load, shift;

  assign load  = (state == IDLE) && bus.blk_valid && !bus.flush;
  assign shift = (state == RUN) && bus.w_ready && !bus.flush;

  sigma0 u_sigma0 (.x(win[1]),  .y(s0));
  sigma1 u_sigma1 (.x(win[14]), .y(s1));

  assign next_word = add4(s1, win[9], s0, win[0]);

  sha256_msg_window u_window (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (bus.blk_data),
    .shift     (shift),
    .new_word  (next_word),
    .win       (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      blk_ready_q <= 1'b1;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      cnt         <= '0;
      blk_ready_q <= 1'b1;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.blk_valid) begin
            state       <= RUN;
            cnt         <= '0;
            blk_ready_q <= 1'b0;
            w_valid_q   <= 1'b1;
            w_last_q    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.w_ready) begin
            if (cnt == LAST_IDX) begin
              state       <= IDLE;
              cnt         <= '0;
              blk_ready_q <= 1'b1;
              w_valid_q   <= 1'b0;
              w_last_q    <= 1'b0;
            end else begin
              cnt      <= cnt + 6'd1;
              w_last_q <= (cnt + 6'd1 == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_last    = w_last_q;
  assign bus.w_data    = win[0];
`ifdef MSG_SCHED_IDX_EN
  assign bus.w_idx     = cnt;
`endif
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench for sha256_msg_schedule
module tb_sha256_msg_schedule;
  import sha256_pkg::*;

  localparam int NW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_msg_schedule_if bus();

  sha256_msg_schedule #(.NUM_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    word_t      data;
    logic       last;
    logic [5:0] idx;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, vcyc = 0, popped = 0, blocks_done = 0;
  int    last_cyc = 0, accept_cyc = 0, last_pos = -1;
  logic  stall_prev = 1'b0;
  word_t held;
  word_t got[NW];
  logic [BLOCK_W-1:0] abc_blk, rnd_blk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t f_s0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t f_s1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // monitor: pops/compares accepted words, pushes the model schedule on block accept
  always @(negedge clk) begin : mon
    word_t w[NW];
    exp_t  e;
    cyc++;
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (bus.w_valid) vcyc++;
      if (stall_prev && bus.w_valid) check("stall_hold", bus.w_data, held);
      stall_prev = bus.w_valid && !bus.w_ready && !bus.flush;
      held = bus.w_data;
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (bus.w_valid && bus.w_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("w_data", bus.w_data, e.data);
            check("w_last", bus.w_last, e.last);
`ifdef MSG_SCHED_IDX_EN
            check("w_idx", bus.w_idx, e.idx);
`endif
            if (popped < NW) got[popped] = bus.w_data;
            if (bus.w_last) last_pos = popped;
            popped++;
            if (e.last) begin
              blocks_done++;
              last_cyc = cyc;
            end
          end
        end
        if (bus.blk_valid && bus.blk_ready) begin
          for (int t = 0; t < NW; t++) begin
            if (t < 16) w[t] = bus.blk_data[511-32*t -: 32];
            else w[t] = f_s1(w[t-2]) + w[t-7] + f_s0(w[t-15]) + w[t-16];
            sb.push_back(exp_t'{w[t], (t == NW-1), 6'(t)});
          end
          accept_cyc = cyc;
          popped = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_block(input logic [BLOCK_W-1:0] d);
    int n;
    @(posedge clk);
    #1;
    bus.blk_data  = d;
    bus.blk_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.blk_ready && n < 300);
    if (n >= 300) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.blk_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (blocks_done < n && k < 1000) begin
      step();
      k++;
    end
    if (k >= 1000) check("done_timeout", blocks_done, n);
  endtask

  initial begin
    int acc0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.flush     = 1'b0;
    bus.w_ready   = 1'b0;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) rnd_blk[511-32*i -: 32] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    check("rst_w_valid", bus.w_valid, 0);
    check("rst_w_last", bus.w_last, 0);
    check("rst_w_data", bus.w_data, 0);
    check("rst_blk_ready", bus.blk_ready, 1);
`ifdef MSG_SCHED_IDX_EN
    check("rst_w_idx", bus.w_idx, 0);
`endif
    rst = 1'b0;

    // "abc" block at full rate
    bus.w_ready = 1'b1;
    vcyc = 0;
    send_block(abc_blk);
    wait_done(1);
    step();
    check("abc_valid_cycles", vcyc, 64);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);
    check("abc_w18", got[18], 32'h7DA86405);
    check("abc_w63", got[63], 32'h12B1EDEB);
    check("abc_last_pos", last_pos, 63);

    // all-zero block, blk_ready the cycle after the last accept
    send_block('0);
    wait_done(2);
    check("zero_w63", got[63], 0);
    step();
    check("zero_blk_ready_after_last", bus.blk_ready, 1);

    // random backpressure
    bus.w_ready = 1'b0;
    send_block(abc_blk);
    for (int i = 0; i < 400 && blocks_done < 3; i++) begin
      @(posedge clk);
      #1;
      bus.w_ready = 1'($urandom_range(0, 1));
    end
    check("rand_done", blocks_done, 3);
    check("rand_w63", got[63], 32'h12B1EDEB);
    bus.w_ready = 1'b1;

    // second block held during RUN
    send_block(abc_blk);
    acc0 = accept_cyc;
    bus.blk_data  = rnd_blk;
    bus.blk_valid = 1'b1;
    for (int k = 0; k < 200 && accept_cyc == acc0; k++) step();
    @(posedge clk);
    #1;
    bus.blk_valid = 1'b0;
    check("b2b_gap", accept_cyc - last_cyc, 1);
    wait_done(5);
    check("b2b_w0", got[0], rnd_blk[511:480]);

    // flush while word 20 is offered
    send_block(abc_blk);
    repeat (20) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    step();
    check("flush_w_valid", bus.w_valid, 0);
    check("flush_blk_ready", bus.blk_ready, 1);
    check("flush_popped", popped, 20);
    send_block(abc_blk);
    wait_done(6);
    check("restart_w0", got[0], 32'h61626380);

    // asynchronous reset mid-block
    send_block(abc_blk);
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_w_valid", bus.w_valid, 0);
    check("arst_w_last", bus.w_last, 0);
    check("arst_w_data", bus.w_data, 0);
    check("arst_blk_ready", bus.blk_ready, 1);
`ifdef MSG_SCHED_IDX_EN
    check("arst_w_idx", bus.w_idx, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_w_valid", bus.w_valid, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
